homography_query_scheduler: RTL and testbench
=============================================

Name: homography_query_scheduler

Overview:
- Sits between the ColorTransform output FIFO and the Homography lookup engine.
- Pops pixel words from the FIFO, issues coordinate queries to the Homography engine, and keeps an in-order tracker of outstanding pixel contexts.
- Pairs each Homography return with its original DVI pixel and drives the synchronised DVI/CCD pixel stream downstream.
- Enforces a credit limit on outstanding queries and flags coordinate mismatches and spurious returns.

Parameters:
DEPTH, 8, max outstanding queries / tracker entries; power of 2, range 2..16
PTR_W, 3, log2(DEPTH)
CNT_W, 4, PTR_W+1, width of the outstanding counter

Ports:
clk_25  in  1  system clock
rst  in  1  asynchronous reset, active-high
enable  in  1  permit new queries
fifo_q  in  44  show-ahead FIFO word: [43:34] x, [33:24] y, [23:16] R8, [15:8] G8, [7:0] B8
fifo_empty  in  1  FIFO empty
fifo_rdreq  out  1  FIFO pop, combinational
query_x  out  10  query x coordinate to Homography
query_y  out  10  query y coordinate to Homography
start  out  1  one-cycle query strobe
ready  in  1  Homography return valid, one cycle per query
return_x  in  10  echoed x coordinate
return_y  in  10  echoed y coordinate
r  in  5  CCD red
g  in  6  CCD green
b  in  5  CCD blue
val  out  1  output pixel valid, one cycle
sync_x  out  10  output pixel x
sync_y  out  10  output pixel y
dvi_r  out  5  DVI red
dvi_g  out  6  DVI green
dvi_b  out  5  DVI blue
ccd_r  out  5  CCD red
ccd_g  out  6  CCD green
ccd_b  out  5  CCD blue
outstanding  out  CNT_W  current tracker occupancy
busy  out  1  state != S_IDLE
mismatch_err  out  1  sticky: return coordinate != tracked coordinate
unexp_err  out  1  sticky: ready seen with empty tracker

Behaviour:
- Reset (rst=1, async):
  - All outputs, the tracker, and the read/write pointers go to 0.
  - State goes to S_IDLE.
  - Asserting rst mid-operation discards every outstanding context; returns arriving after release count as unexpected.
- Issue condition (combinational): issue = enable && !fifo_empty && (outstanding < DEPTH) && state != S_DRAIN.
  - fifo_rdreq = issue.
- On an issue edge (registered):
  - start=1; query_x=fifo_q[43:34]; query_y=fifo_q[33:24].
  - Push the 36-bit context {x, y, R8[7:3], G8[7:2], B8[7:3]} at the write pointer; the write pointer wraps modulo DEPTH.
  - start=0 on any cycle without an issue; query_x/query_y hold their last values.
  - Back-to-back issues are allowed, one per cycle.
- Return (ready=1, outstanding>0):
  - Pop the context at the read pointer.
  - Next edge: val=1, sync_x/sync_y/dvi_* from the context, ccd_* from r/g/b.
  - If return_x/return_y differ from the context coordinates, set mismatch_err=1.
  - Latency is ready-to-val = 1 cycle. Outputs other than val hold between returns.
- Return with empty tracker (ready=1, outstanding==0): set unexp_err=1, val stays 0, and outputs are unchanged.
- Simultaneous issue and return: push and pop happen in the same cycle and outstanding is unchanged.
  - At outstanding==DEPTH, issue is blocked even when a return coincides (no same-cycle credit reuse).
- Error flags clear only on rst.
- FSM:
  - S_IDLE: enable=1 -> S_RUN.
  - S_RUN: enable=0 and outstanding==0 -> S_IDLE; enable=0 and outstanding>0 -> S_DRAIN.
  - S_DRAIN: no issues; when outstanding reaches 0 (including a pop that empties it) -> S_IDLE. Re-asserting enable in S_DRAIN has no effect until S_IDLE.
  - The issue condition in S_IDLE is evaluated with the current enable, so the first issue may occur in the same cycle enable rises.
- Arithmetic:
  - outstanding = wr_ptr - rd_ptr tracked as a CNT_W-bit counter: +1 on push only, -1 on pop only.
  - Colour truncation is by MSB selection only; no rounding.

Test Plan:
- Single pixel:
  - Stimulus: fifo_q = {10'd100, 10'd50, 8'hF8, 8'hFC, 8'hF8}, enable=1.
  - Response: fifo_rdreq=1 for 1 cycle; next cycle start=1 with query (100,50).
  - Then ready 3 cycles later with (100,50), rgb = (5'd3, 6'd7, 5'd9).
  - Response: one cycle later val=1, sync=(100,50), dvi=(31,63,31), ccd=(3,7,9), no error flags.
- Credit limit, DEPTH=8, 12 FIFO words, ready held 0:
  - Exactly 8 rdreq/start pulses; outstanding=8; fifo_rdreq stays 0.
  - After one ready, the 9th issue occurs on the following cycle.
- Streaming: a word every cycle with ready returning each query 4 cycles later.
  - outstanding settles at 4; val sequence matches FIFO order; wrap-around passes 20 pixels without loss.
- Mismatch: return_y=51 for a query of (100,50) -> mismatch_err=1 and stays 1; val is still asserted with sync_y=50.
- Spurious ready: ready pulse with outstanding=0 -> unexp_err=1, val=0, outputs unchanged.
- Drain and reset:
  - enable drops with 3 outstanding -> busy=1 in S_DRAIN, no new start.
  - After 3 readys -> S_IDLE, busy=0.
  - rst pulse with 2 outstanding -> outstanding=0, val=0; a later ready sets unexp_err.

Source files
------------

// File: rtl/homography_query_scheduler.sv
// Homography query scheduler: pops pixel words, issues coordinate queries and
// re-pairs in-order Homography returns with their tracked DVI pixel context.
module homography_query_scheduler #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3,
    parameter int CNT_W = 4
) (
    input  logic             clk_25,
    input  logic             rst,
    input  logic             enable,
    input  logic [43:0]      fifo_q,
    input  logic             fifo_empty,
    output logic             fifo_rdreq,
    output logic [9:0]       query_x,
    output logic [9:0]       query_y,
    output logic             start,
    input  logic             ready,
    input  logic [9:0]       return_x,
    input  logic [9:0]       return_y,
    input  logic [4:0]       r,
    input  logic [5:0]       g,
    input  logic [4:0]       b,
    output logic             val,
    output logic [9:0]       sync_x,
    output logic [9:0]       sync_y,
    output logic [4:0]       dvi_r,
    output logic [5:0]       dvi_g,
    output logic [4:0]       dvi_b,
    output logic [4:0]       ccd_r,
    output logic [5:0]       ccd_g,
    output logic [4:0]       ccd_b,
    output logic [CNT_W-1:0] outstanding,
    output logic             busy,
    output logic             mismatch_err,
    output logic             unexp_err,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam int CTX_W = 36;

    // Query side: start is a one-cycle strobe with no backpressure; each ready
    // pulse is one return, accepted unconditionally, in the order queries left.
    state_t           state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CTX_W-1:0] ctx_q [DEPTH];
    logic [CTX_W-1:0] ctx_d [DEPTH];
    logic [CTX_W-1:0] head_ctx;
    logic             issue, pop, spurious;

    logic       start_q, start_d;
    logic [9:0] query_x_q, query_x_d, query_y_q, query_y_d;
    logic       val_q, val_d;
    logic [9:0] sync_x_q, sync_x_d, sync_y_q, sync_y_d;
    logic [4:0] dvi_r_q, dvi_r_d, dvi_b_q, dvi_b_d;
    logic [5:0] dvi_g_q, dvi_g_d;
    logic [4:0] ccd_r_q, ccd_r_d, ccd_b_q, ccd_b_d;
    logic [5:0] ccd_g_q, ccd_g_d;
    logic       mismatch_q, mismatch_d, unexp_q, unexp_d;

    // Colour LSBs dropped by MSB truncation.
    logic unused_colour_lsbs;
    assign unused_colour_lsbs = ^{fifo_q[18:16], fifo_q[9:8], fifo_q[2:0]};

    always_comb begin
        issue    = enable && !fifo_empty && (cnt_q < CNT_W'(DEPTH)) && (state_q != S_DRAIN);
        pop      = ready && (cnt_q != '0);
        spurious = ready && (cnt_q == '0);
        head_ctx = ctx_q[rd_ptr_q];

        ctx_d      = ctx_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        start_d    = issue;
        query_x_d  = query_x_q;
        query_y_d  = query_y_q;
        val_d      = pop;
        sync_x_d   = sync_x_q;
        sync_y_d   = sync_y_q;
        dvi_r_d    = dvi_r_q;
        dvi_g_d    = dvi_g_q;
        dvi_b_d    = dvi_b_q;
        ccd_r_d    = ccd_r_q;
        ccd_g_d    = ccd_g_q;
        ccd_b_d    = ccd_b_q;
        mismatch_d = mismatch_q;
        unexp_d    = unexp_q | spurious;

        if (issue) begin
            ctx_d[wr_ptr_q] = {fifo_q[43:24], fifo_q[23:19], fifo_q[15:10], fifo_q[7:3]};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            query_x_d       = fifo_q[43:34];
            query_y_d       = fifo_q[33:24];
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            sync_x_d = head_ctx[35:26];
            sync_y_d = head_ctx[25:16];
            dvi_r_d  = head_ctx[15:11];
            dvi_g_d  = head_ctx[10:5];
            dvi_b_d  = head_ctx[4:0];
            ccd_r_d  = r;
            ccd_g_d  = g;
            ccd_b_d  = b;
            if ((return_x != head_ctx[35:26]) || (return_y != head_ctx[25:16])) begin
                mismatch_d = 1'b1;
            end
        end

        unique case ({issue, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (enable) state_d = S_RUN;
            S_RUN:   if (!enable) state_d = (cnt_d == '0) ? S_IDLE : S_DRAIN;
            S_DRAIN: if (cnt_d == '0) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_25 or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            for (int i = 0; i < DEPTH; i++) ctx_q[i] <= '0;
            start_q    <= 1'b0;
            query_x_q  <= '0;
            query_y_q  <= '0;
            val_q      <= 1'b0;
            sync_x_q   <= '0;
            sync_y_q   <= '0;
            dvi_r_q    <= '0;
            dvi_g_q    <= '0;
            dvi_b_q    <= '0;
            ccd_r_q    <= '0;
            ccd_g_q    <= '0;
            ccd_b_q    <= '0;
            mismatch_q <= 1'b0;
            unexp_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            for (int i = 0; i < DEPTH; i++) ctx_q[i] <= ctx_d[i];
            start_q    <= start_d;
            query_x_q  <= query_x_d;
            query_y_q  <= query_y_d;
            val_q      <= val_d;
            sync_x_q   <= sync_x_d;
            sync_y_q   <= sync_y_d;
            dvi_r_q    <= dvi_r_d;
            dvi_g_q    <= dvi_g_d;
            dvi_b_q    <= dvi_b_d;
            ccd_r_q    <= ccd_r_d;
            ccd_g_q    <= ccd_g_d;
            ccd_b_q    <= ccd_b_d;
            mismatch_q <= mismatch_d;
            unexp_q    <= unexp_d;
        end
    end

    assign fifo_rdreq   = issue;
    assign start        = start_q;
    assign query_x      = query_x_q;
    assign query_y      = query_y_q;
    assign val          = val_q;
    assign sync_x       = sync_x_q;
    assign sync_y       = sync_y_q;
    assign dvi_r        = dvi_r_q;
    assign dvi_g        = dvi_g_q;
    assign dvi_b        = dvi_b_q;
    assign ccd_r        = ccd_r_q;
    assign ccd_g        = ccd_g_q;
    assign ccd_b        = ccd_b_q;
    assign outstanding  = cnt_q;
    assign busy         = (state_q != S_IDLE);
    assign mismatch_err = mismatch_q;
    assign unexp_err    = unexp_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_homography_query_scheduler.sv
// Directed bench for homography_query_scheduler: issue, credit limit,
// streaming order, error flags, drain and mid-run reset.
module tb_homography_query_scheduler;

  logic        clk_25 = 1'b0;
  logic        rst;
  logic        enable;
  logic [43:0] fifo_q;
  logic        fifo_empty;
  logic        fifo_rdreq;
  logic [9:0]  query_x, query_y;
  logic        start;
  logic        ready;
  logic [9:0]  return_x, return_y;
  logic [4:0]  r, b;
  logic [5:0]  g;
  logic        val;
  logic [9:0]  sync_x, sync_y;
  logic [4:0]  dvi_r, dvi_b, ccd_r, ccd_b;
  logic [5:0]  dvi_g, ccd_g;
  logic [3:0]  outstanding;
  logic        busy, mismatch_err, unexp_err;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int n_starts = 0;
  int val_cnt = 0;
  int resp_n = 0;
  bit auto_resp = 0;

  logic [43:0] fq[$];
  logic [43:0] iss_q[$];
  int          due_q[$];
  logic [51:0] exp_q[$];

  homography_query_scheduler #(.DEPTH(8), .PTR_W(3), .CNT_W(4)) dut (
    .clk_25(clk_25), .rst(rst), .enable(enable), .fifo_q(fifo_q), .fifo_empty(fifo_empty),
    .fifo_rdreq(fifo_rdreq), .query_x(query_x), .query_y(query_y), .start(start),
    .ready(ready), .return_x(return_x), .return_y(return_y), .r(r), .g(g), .b(b),
    .val(val), .sync_x(sync_x), .sync_y(sync_y), .dvi_r(dvi_r), .dvi_g(dvi_g), .dvi_b(dvi_b),
    .ccd_r(ccd_r), .ccd_g(ccd_g), .ccd_b(ccd_b), .outstanding(outstanding), .busy(busy),
    .mismatch_err(mismatch_err), .unexp_err(unexp_err), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk_25 = ~clk_25;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [43:0] mk(int x, int y, int rr, int gg, int bb);
    return {10'(x), 10'(y), 8'(rr), 8'(gg), 8'(bb)};
  endfunction

  task automatic drive_fifo();
    fifo_empty = (fq.size() == 0);
    fifo_q = fifo_empty ? 44'd0 : fq[0];
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; ready = 1'b0;
    return_x = '0; return_y = '0; r = '0; g = '0; b = '0;
    fq.delete(); iss_q.delete(); due_q.delete(); exp_q.delete();
    auto_resp = 0; val_cnt = 0; n_starts = 0; resp_n = 0;
    drive_fifo();
    repeat (2) @(posedge clk_25);
    #1 rst = 1'b0;
    #1;
  endtask

  // One clock: FIFO pop model, auto responder and streaming scoreboard.
  task automatic cycle();
    logic        popped;
    logic [43:0] w;
    logic [51:0] got, expv;
    popped = fifo_rdreq;
    @(posedge clk_25); #1;
    cyc++;
    if (popped && fq.size() > 0) begin
      w = fq.pop_front();
      if (auto_resp) begin iss_q.push_back(w); due_q.push_back(cyc + 3); end
    end
    if (start) n_starts++;
    if (auto_resp && val) begin
      val_cnt++;
      n_cmp++;
      got = {sync_x, sync_y, dvi_r, dvi_g, dvi_b, ccd_r, ccd_g, ccd_b};
      if (exp_q.size() == 0) begin
        n_err++; $display("FAIL stream_val: got val with %h, required no pending pixel", got);
      end else begin
        expv = exp_q.pop_front();
        if (got !== expv) begin n_err++; $display("FAIL stream_pixel: got %h required %h", got, expv); end
      end
    end
    ready = 1'b0;
    if (auto_resp && due_q.size() > 0 && due_q[0] == cyc) begin
      w = iss_q.pop_front();
      void'(due_q.pop_front());
      ready = 1'b1; return_x = w[43:34]; return_y = w[33:24];
      r = 5'(resp_n); g = 6'(resp_n * 3); b = 5'(31 - resp_n);
      exp_q.push_back({w[43:34], w[33:24], w[23:19], w[15:10], w[7:3], r, g, b});
      resp_n++;
    end
    drive_fifo();
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (start !== 1'b0) begin n_err++; $display("FAIL rst_start: got %0b required 0", start); end
    n_cmp++; if (val !== 1'b0) begin n_err++; $display("FAIL rst_val: got %0b required 0", val); end
    n_cmp++; if (outstanding !== 4'd0) begin n_err++; $display("FAIL rst_outstanding: got %0d required 0", outstanding); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %0b required 0", busy); end
    n_cmp++; if ({mismatch_err, unexp_err} !== 2'b00) begin n_err++; $display("FAIL rst_errs: got %b required 00", {mismatch_err, unexp_err}); end
    n_cmp++; if ({query_x, query_y, sync_x, sync_y} !== 40'd0) begin n_err++; $display("FAIL rst_coords: got %h required 0", {query_x, query_y, sync_x, sync_y}); end
    n_cmp++; if ({dvi_r, dvi_g, dvi_b, ccd_r, ccd_g, ccd_b} !== 32'd0) begin n_err++; $display("FAIL rst_colours: got %h required 0", {dvi_r, dvi_g, dvi_b, ccd_r, ccd_g, ccd_b}); end
    n_cmp++; if (fifo_rdreq !== 1'b0) begin n_err++; $display("FAIL rst_rdreq: got %0b required 0", fifo_rdreq); end
  endtask

  task automatic test_single_pixel();
    do_reset();
    fq.push_back(mk(100, 50, 8'hF8, 8'hFC, 8'hF8));
    enable = 1'b1; drive_fifo(); #1;
    n_cmp++; if (fifo_rdreq !== 1'b1) begin n_err++; $display("FAIL sp_rdreq: got %0b required 1", fifo_rdreq); end
    cycle();
    n_cmp++; if (start !== 1'b1) begin n_err++; $display("FAIL sp_start: got %0b required 1", start); end
    n_cmp++; if ({query_x, query_y} !== {10'd100, 10'd50}) begin n_err++; $display("FAIL sp_query: got (%0d,%0d) required (100,50)", query_x, query_y); end
    n_cmp++; if (outstanding !== 4'd1 || busy !== 1'b1) begin n_err++; $display("FAIL sp_occ: got out=%0d busy=%0b required 1/1", outstanding, busy); end
    n_cmp++; if (fifo_rdreq !== 1'b0) begin n_err++; $display("FAIL sp_rdreq_once: got %0b required 0", fifo_rdreq); end
    cycle();
    n_cmp++; if (start !== 1'b0) begin n_err++; $display("FAIL sp_start_pulse: got %0b required 0", start); end
    cycle(); cycle();
    ready = 1'b1; return_x = 10'd100; return_y = 10'd50; r = 5'd3; g = 6'd7; b = 5'd9;
    cycle();
    n_cmp++; if (val !== 1'b1) begin n_err++; $display("FAIL sp_val: got %0b required 1", val); end
    n_cmp++; if ({sync_x, sync_y} !== {10'd100, 10'd50}) begin n_err++; $display("FAIL sp_sync: got (%0d,%0d) required (100,50)", sync_x, sync_y); end
    n_cmp++; if ({dvi_r, dvi_g, dvi_b} !== {5'd31, 6'd63, 5'd31}) begin n_err++; $display("FAIL sp_dvi: got (%0d,%0d,%0d) required (31,63,31)", dvi_r, dvi_g, dvi_b); end
    n_cmp++; if ({ccd_r, ccd_g, ccd_b} !== {5'd3, 6'd7, 5'd9}) begin n_err++; $display("FAIL sp_ccd: got (%0d,%0d,%0d) required (3,7,9)", ccd_r, ccd_g, ccd_b); end
    n_cmp++; if ({mismatch_err, unexp_err} !== 2'b00 || outstanding !== 4'd0) begin n_err++; $display("FAIL sp_errs: got err=%b out=%0d required 00/0", {mismatch_err, unexp_err}, outstanding); end
    cycle();
    n_cmp++; if (val !== 1'b0 || sync_x !== 10'd100) begin n_err++; $display("FAIL sp_hold: got val=%0b x=%0d required 0/100", val, sync_x); end
  endtask

  task automatic test_credit_limit();
    do_reset();
    for (int i = 0; i < 12; i++) fq.push_back(mk(i, 200 + i, i * 16, i * 8, i * 4));
    enable = 1'b1; drive_fifo(); #1;
    repeat (12) cycle();
    n_cmp++; if (n_starts !== 8) begin n_err++; $display("FAIL cr_starts: got %0d required 8", n_starts); end
    n_cmp++; if (outstanding !== 4'd8) begin n_err++; $display("FAIL cr_outstanding: got %0d required 8", outstanding); end
    n_cmp++; if (fq.size() !== 4) begin n_err++; $display("FAIL cr_pops: got %0d words left required 4", fq.size()); end
    ready = 1'b1; return_x = 10'd0; return_y = 10'd200; #1;
    n_cmp++; if (fifo_rdreq !== 1'b0) begin n_err++; $display("FAIL cr_no_reuse: got %0b required 0", fifo_rdreq); end
    cycle();
    n_cmp++; if (val !== 1'b1 || {sync_x, sync_y} !== {10'd0, 10'd200}) begin n_err++; $display("FAIL cr_ret: got val=%0b (%0d,%0d) required 1 (0,200)", val, sync_x, sync_y); end
    n_cmp++; if (outstanding !== 4'd7 || fifo_rdreq !== 1'b1) begin n_err++; $display("FAIL cr_credit: got out=%0d rdreq=%0b required 7/1", outstanding, fifo_rdreq); end
    cycle();
    n_cmp++; if (start !== 1'b1 || {query_x, query_y} !== {10'd8, 10'd208}) begin n_err++; $display("FAIL cr_ninth: got start=%0b (%0d,%0d) required 1 (8,208)", start, query_x, query_y); end
    n_cmp++; if (outstanding !== 4'd8 || n_starts !== 9) begin n_err++; $display("FAIL cr_refill: got out=%0d starts=%0d required 8/9", outstanding, n_starts); end
  endtask

  task automatic test_streaming();
    do_reset();
    for (int i = 0; i < 20; i++) fq.push_back(mk(10 * i + 3, 479 - i, i * 13, i * 29 + 7, 255 - i * 11));
    auto_resp = 1; enable = 1'b1; drive_fifo(); #1;
    for (int c = 1; c <= 30; c++) begin
      cycle();
      if (c == 10) begin
        n_cmp++; if (outstanding !== 4'd4) begin n_err++; $display("FAIL st_settle: got %0d required 4", outstanding); end
      end
    end
    n_cmp++; if (val_cnt !== 20 || exp_q.size() !== 0) begin n_err++; $display("FAIL st_count: got %0d vals %0d pending required 20/0", val_cnt, exp_q.size()); end
    n_cmp++; if (outstanding !== 4'd0 || iss_q.size() !== 0) begin n_err++; $display("FAIL st_empty: got out=%0d unreturned=%0d required 0/0", outstanding, iss_q.size()); end
    n_cmp++; if ({mismatch_err, unexp_err} !== 2'b00) begin n_err++; $display("FAIL st_errs: got %b required 00", {mismatch_err, unexp_err}); end
    auto_resp = 0;
  endtask

  task automatic test_mismatch();
    do_reset();
    fq.push_back(mk(100, 50, 8'hF8, 8'hFC, 8'hF8));
    enable = 1'b1; drive_fifo(); #1;
    cycle(); cycle();
    ready = 1'b1; return_x = 10'd100; return_y = 10'd51; r = 5'd3; g = 6'd7; b = 5'd9;
    cycle();
    n_cmp++; if (mismatch_err !== 1'b1) begin n_err++; $display("FAIL mm_flag: got %0b required 1", mismatch_err); end
    n_cmp++; if (val !== 1'b1 || sync_y !== 10'd50) begin n_err++; $display("FAIL mm_val: got val=%0b y=%0d required 1/50", val, sync_y); end
    repeat (3) cycle();
    n_cmp++; if (mismatch_err !== 1'b1 || unexp_err !== 1'b0) begin n_err++; $display("FAIL mm_sticky: got mm=%0b ux=%0b required 1/0", mismatch_err, unexp_err); end
  endtask

  task automatic test_spurious();
    ready = 1'b1; return_x = 10'd7; return_y = 10'd7; r = 5'd1; g = 6'd1; b = 5'd1;
    cycle();
    n_cmp++; if (unexp_err !== 1'b1) begin n_err++; $display("FAIL sx_flag: got %0b required 1", unexp_err); end
    n_cmp++; if (val !== 1'b0) begin n_err++; $display("FAIL sx_val: got %0b required 0", val); end
    n_cmp++; if ({sync_x, sync_y, ccd_r, ccd_g, ccd_b} !== {10'd100, 10'd50, 5'd3, 6'd7, 5'd9}) begin n_err++; $display("FAIL sx_hold: got (%0d,%0d) ccd (%0d,%0d,%0d) required (100,50) (3,7,9)", sync_x, sync_y, ccd_r, ccd_g, ccd_b); end
    n_cmp++; if (outstanding !== 4'd0 || mismatch_err !== 1'b1) begin n_err++; $display("FAIL sx_state: got out=%0d mm=%0b required 0/1", outstanding, mismatch_err); end
  endtask

  task automatic test_drain_reset();
    do_reset();
    for (int i = 0; i < 3; i++) fq.push_back(mk(300 + i, 10 + i, 8'h80, 8'h40, 8'h20));
    enable = 1'b1; drive_fifo(); #1;
    repeat (3) cycle();
    n_cmp++; if (outstanding !== 4'd3) begin n_err++; $display("FAIL dr_fill: got %0d required 3", outstanding); end
    enable = 1'b0;
    for (int i = 3; i < 5; i++) fq.push_back(mk(300 + i, 10 + i, 8'h80, 8'h40, 8'h20));
    drive_fifo(); #1;
    cycle();
    n_cmp++; if (busy !== 1'b1 || dbg_state !== 2'd2 || start !== 1'b0) begin n_err++; $display("FAIL dr_enter: got busy=%0b st=%0d start=%0b required 1/2/0", busy, dbg_state, start); end
    enable = 1'b1; #1;
    n_cmp++; if (fifo_rdreq !== 1'b0) begin n_err++; $display("FAIL dr_reenable: got %0b required 0", fifo_rdreq); end
    cycle();
    n_cmp++; if (start !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL dr_nostart: got start=%0b busy=%0b required 0/1", start, busy); end
    for (int k = 0; k < 3; k++) begin
      ready = 1'b1; return_x = 10'(300 + k); return_y = 10'(10 + k); r = 5'd2; g = 6'd4; b = 5'd6;
      cycle();
    end
    n_cmp++; if (outstanding !== 4'd0 || busy !== 1'b0 || dbg_state !== 2'd0) begin n_err++; $display("FAIL dr_idle: got out=%0d busy=%0b st=%0d required 0/0/0", outstanding, busy, dbg_state); end
    n_cmp++; if (val !== 1'b1 || sync_x !== 10'd302 || start !== 1'b0) begin n_err++; $display("FAIL dr_last: got val=%0b x=%0d start=%0b required 1/302/0", val, sync_x, start); end
    n_cmp++; if (fifo_rdreq !== 1'b1 || mismatch_err !== 1'b0) begin n_err++; $display("FAIL dr_resume: got rdreq=%0b mm=%0b required 1/0", fifo_rdreq, mismatch_err); end
    repeat (2) cycle();
    n_cmp++; if (outstanding !== 4'd2 || busy !== 1'b1) begin n_err++; $display("FAIL dr_refill: got out=%0d busy=%0b required 2/1", outstanding, busy); end
    enable = 1'b0; fq.delete(); drive_fifo();
    rst = 1'b1; #1;
    n_cmp++; if (outstanding !== 4'd0 || val !== 1'b0 || busy !== 1'b0 || start !== 1'b0) begin n_err++; $display("FAIL dr_rst: got out=%0d val=%0b busy=%0b start=%0b required 0/0/0/0", outstanding, val, busy, start); end
    @(negedge clk_25); rst = 1'b0;
    ready = 1'b1; return_x = 10'd303; return_y = 10'd13;
    cycle();
    n_cmp++; if (unexp_err !== 1'b1 || val !== 1'b0 || outstanding !== 4'd0) begin n_err++; $display("FAIL dr_late_ret: got ux=%0b val=%0b out=%0d required 1/0/0", unexp_err, val, outstanding); end
  endtask

  initial begin
    test_reset();
    test_single_pixel();
    test_credit_limit();
    test_streaming();
    test_mismatch();
    test_spurious();
    test_drain_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
